// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory bus arbiter.
// Configuration macro: MEM_ARB_FIXED_PRIO_EN (fixed-priority arbitration when defined).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic READ   = 1'b1;
  localparam logic WRITE  = 1'b0;
  localparam int   ADDR_W = 8;
  localparam int   DATA_W = 8;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester and memory-side signals of the arbiter, bundled in one interface.
// master: the arbiter's view; slave: the requesters/memory environment.
interface mem_bus_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        req_rw;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        ack;
  logic [DATA_W-1:0]      rdata;
  logic [NREQ-1:0]        grant;
  logic                   busy;
  logic                   mem_start;
  logic                   mem_rw;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic                   mem_wdata_oe;
  logic [DATA_W-1:0]      mem_rdata;

  modport master (
    input  req, req_rw, req_addr, req_wdata, mem_rdata,
    output ack, rdata, grant, busy, mem_start, mem_rw, mem_addr, mem_wdata, mem_wdata_oe
  );

  modport slave (
    output req, req_rw, req_addr, req_wdata, mem_rdata,
    input  ack, rdata, grant, busy, mem_start, mem_rw, mem_addr, mem_wdata, mem_wdata_oe
  );
endinterface

// File: rtl/mem_rr_pick.sv
// Combinational winner selection for the arbiter.
// Default: round-robin starting at ptr, also returns the pointer for the next grant.
// MEM_ARB_FIXED_PRIO_EN defined: lowest set index wins, no pointer ports.
module mem_rr_pick #(
  parameter int NREQ = 2
`ifndef MEM_ARB_FIXED_PRIO_EN
  , localparam int PTR_W = $clog2(NREQ)
`endif
) (
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  win
`ifndef MEM_ARB_FIXED_PRIO_EN
  , input  logic [PTR_W-1:0] ptr
  , output logic [PTR_W-1:0] next_ptr
`endif
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  // Isolate the lowest set request bit.
  assign win = req & (~req + NREQ'(1));
`else
  logic [NREQ-1:0]  mask;
  logic [NREQ-1:0]  upper;
  logic [NREQ-1:0]  pool;
  logic [PTR_W-1:0] idx_acc [NREQ+1];

  // Requests at or above the pointer get first chance; wrap to the bottom otherwise.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
    assign mask[gi] = (PTR_W'(gi) >= ptr);
  end

  assign upper = req & mask;
  assign pool  = (|upper) ? upper : req;
  assign win   = pool & (~pool + NREQ'(1));

  // Encode the one-hot winner so the pointer can move just past it.
  assign idx_acc[0] = '0;
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_enc
    assign idx_acc[gi+1] = idx_acc[gi] | (win[gi] ? PTR_W'(gi) : '0);
  end

  assign next_ptr = (idx_acc[NREQ] == PTR_W'(NREQ - 1)) ? '0 : idx_acc[NREQ] + PTR_W'(1);
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one 8-bit memory between NREQ requesters: IDLE -> ISSUE -> ACCESS -> RESP.
// Write data is driven onto the bus only in a write's ISSUE/ACCESS cycles.
// Configuration macro: MEM_ARB_FIXED_PRIO_EN selects fixed priority (no pointer register).
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = mem_arb_pkg::ADDR_W,
  parameter int DATA_W = mem_arb_pkg::DATA_W
) (
  input logic               CLK,
  input logic               RST,
  mem_bus_arbiter_if.master bus
);

  state_t              state;
  logic [NREQ-1:0]     win;
  logic [NREQ-1:0]     ack_reg;
  logic [NREQ-1:0]     grant_reg;
  logic                busy_reg;
  logic                start_reg;
  logic                rw_reg;
  logic                oe_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [DATA_W-1:0]   rdata_reg;

  logic                sel_rw;
  logic [ADDR_W-1:0]   addr_acc  [NREQ+1];
  logic [DATA_W-1:0]   wdata_acc [NREQ+1];

`ifdef MEM_ARB_FIXED_PRIO_EN
  mem_rr_pick #(.NREQ(NREQ)) u_pick (
    .req (bus.req),
    .win (win)
  );
`else
  localparam int PTR_W = $clog2(NREQ);
  logic [PTR_W-1:0] ptr_reg;
  logic [PTR_W-1:0] next_ptr;

  mem_rr_pick #(.NREQ(NREQ)) u_pick (
    .req      (bus.req),
    .win      (win),
    .ptr      (ptr_reg),
    .next_ptr (next_ptr)
  );
`endif

  // Route the winner's command fields through a one-hot AND-OR mux.
  assign sel_rw       = |(win & bus.req_rw);
  assign addr_acc[0]  = '0;
  assign wdata_acc[0] = '0;
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_sel
    assign addr_acc[gi+1]  = addr_acc[gi]  | (win[gi] ? bus.req_addr[gi*ADDR_W +: ADDR_W]  : '0);
    assign wdata_acc[gi+1] = wdata_acc[gi] | (win[gi] ? bus.req_wdata[gi*DATA_W +: DATA_W] : '0);
  end

  // Transaction FSM; every output is a register so the bus control is glitch-free.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      ack_reg   <= '0;
      grant_reg <= '0;
      busy_reg  <= 1'b0;
      start_reg <= 1'b0;
      rw_reg    <= READ;
      oe_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      ptr_reg   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            grant_reg <= win;
            busy_reg  <= 1'b1;
            start_reg <= 1'b1;
            rw_reg    <= sel_rw;
            addr_reg  <= addr_acc[NREQ];
            // Write data is only presented while the bus is driven.
            oe_reg    <= (sel_rw == WRITE);
            wdata_reg <= (sel_rw == WRITE) ? wdata_acc[NREQ] : '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            ptr_reg   <= next_ptr;
`endif
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          start_reg <= 1'b0;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (rw_reg == READ) begin
            rdata_reg <= bus.mem_rdata;
          end
          oe_reg    <= 1'b0;
          wdata_reg <= '0;
          ack_reg   <= grant_reg;
          state     <= RESP;
        end
        RESP: begin
          ack_reg   <= '0;
          grant_reg <= '0;
          busy_reg  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack          = ack_reg;
  assign bus.rdata        = rdata_reg;
  assign bus.grant        = grant_reg;
  assign bus.busy         = busy_reg;
  assign bus.mem_start    = start_reg;
  assign bus.mem_rw       = rw_reg;
  assign bus.mem_addr     = addr_reg;
  assign bus.mem_wdata    = wdata_reg;
  assign bus.mem_wdata_oe = oe_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a 256x8 memory model on the bus side.
// Honours MEM_ARB_FIXED_PRIO_EN for the contention expectations.
module tb_mem_bus_arbiter;
  import mem_arb_pkg::*;

  localparam int NREQ = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.NREQ(NREQ), .ADDR_W(8), .DATA_W(8)) bus_if ();

  mem_bus_arbiter #(.NREQ(NREQ), .ADDR_W(8), .DATA_W(8)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus_if.master)
  );

  // Memory model: command captured on mem_start, access happens the following cycle.
  logic [7:0] mem [256];
  logic       mem_init  = 1'b1;
  logic       in_access = 1'b0;
  logic       cap_rw    = 1'b1;
  logic [7:0] cap_addr  = 8'h00;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 8'h3C) ? 8'hA5 : 8'h00;
    end else if (in_access && !cap_rw && bus_if.mem_wdata_oe) begin
      mem[cap_addr] <= bus_if.mem_wdata;
    end
    in_access <= bus_if.mem_start;
    if (bus_if.mem_start) begin
      cap_rw   <= bus_if.mem_rw;
      cap_addr <= bus_if.mem_addr;
    end
  end

  assign bus_if.mem_rdata = (in_access && cap_rw && !bus_if.mem_wdata_oe) ? mem[cap_addr] : 8'h00;

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         idx;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  // One single-requester transaction, entered during an IDLE cycle, leaves at an IDLE negedge.
  task automatic run_txn(input int idx, input logic rw, input logic [7:0] addr,
                         input logic [7:0] wdata, input logic [7:0] exp_rdata);
    logic [NREQ-1:0] onehot;
    onehot      = '0;
    onehot[idx] = 1'b1;
    bus_if.req_rw[idx]            = rw;
    bus_if.req_addr[idx*8 +: 8]   = addr;
    bus_if.req_wdata[idx*8 +: 8]  = wdata;
    bus_if.req[idx]               = 1'b1;
    @(negedge clk); // ISSUE
    check("issue_start", bus_if.mem_start, 1);
    check("issue_rw",    bus_if.mem_rw, rw);
    check("issue_addr",  bus_if.mem_addr, addr);
    check("issue_grant", bus_if.grant, onehot);
    check("issue_oe",    bus_if.mem_wdata_oe, (rw == WRITE));
    check("issue_wdata", bus_if.mem_wdata, (rw == WRITE) ? wdata : 8'h00);
    check("issue_busy",  bus_if.busy, 1);
    // Scramble inputs after the latch edge; the latched command must stand.
    bus_if.req_addr[idx*8 +: 8]  = ~addr;
    bus_if.req_wdata[idx*8 +: 8] = ~wdata;
    bus_if.req_rw[idx]           = ~rw;
    @(negedge clk); // ACCESS
    check("access_start", bus_if.mem_start, 0);
    check("access_oe",    bus_if.mem_wdata_oe, (rw == WRITE));
    check("access_addr",  bus_if.mem_addr, addr);
    check("access_ack",   bus_if.ack, 0);
    @(negedge clk); // RESP
    check("resp_ack",   bus_if.ack, onehot);
    check("resp_rdata", bus_if.rdata, exp_rdata);
    check("resp_oe",    bus_if.mem_wdata_oe, 0);
    @(posedge clk);
    #1 bus_if.req[idx] = 1'b0;
    @(negedge clk); // IDLE
    check("idle_ack",   bus_if.ack, 0);
    check("idle_grant", bus_if.grant, 0);
    check("idle_busy",  bus_if.busy, 0);
    $display("[TB] txn req%0d %s addr=%02h wdata=%02h rdata=%02h", idx,
             (rw == READ) ? "READ " : "WRITE", addr, wdata, bus_if.rdata);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] exp_g;
    logic [7:0]      exp_d;
    bit              seen;

    vecs[0] = '{0, READ,  8'h3C, 8'h00, 8'hA5};
    vecs[1] = '{1, WRITE, 8'h10, 8'h5A, 8'hA5};
    vecs[2] = '{0, READ,  8'h10, 8'h00, 8'h5A};
    vecs[3] = '{1, WRITE, 8'hFF, 8'hC3, 8'h5A};
    vecs[4] = '{1, READ,  8'hFF, 8'h00, 8'hC3};
    vecs[5] = '{0, WRITE, 8'h00, 8'h11, 8'hC3};
    vecs[6] = '{1, READ,  8'h00, 8'h00, 8'h11};

    bus_if.req       = '0;
    bus_if.req_rw    = '1;
    bus_if.req_addr  = '0;
    bus_if.req_wdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    mem_init = 1'b0;
    check("rst_ack",   bus_if.ack, 0);
    check("rst_grant", bus_if.grant, 0);
    check("rst_busy",  bus_if.busy, 0);
    check("rst_start", bus_if.mem_start, 0);
    check("rst_oe",    bus_if.mem_wdata_oe, 0);
    check("rst_rdata", bus_if.rdata, 0);
    check("rst_addr",  bus_if.mem_addr, 0);
    check("rst_wdata", bus_if.mem_wdata, 0);
    check("rst_rw",    bus_if.mem_rw, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Contention: both requesters held high for four transactions
    bus_if.req_rw   = 2'b11;
    bus_if.req_addr = {8'h10, 8'h3C};
    bus_if.req      = 2'b11;
    for (int t = 0; t < 4; t++) begin
      seen = 1'b0;
      for (int c = 0; c < 8 && !seen; c++) begin
        @(negedge clk);
        if (bus_if.mem_start) seen = 1'b1;
      end
      check("cont_start_seen", seen, 1);
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp_g = 2'b01;
`else
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
`endif
      exp_d = (exp_g == 2'b01) ? 8'hA5 : 8'h00;
      check("cont_grant", bus_if.grant, exp_g);
      @(negedge clk);
      @(negedge clk);
      check("cont_ack",   bus_if.ack, exp_g);
      check("cont_rdata", bus_if.rdata, exp_d);
      $display("[TB] txn contention #%0d grant=%b ack=%b rdata=%02h", t, bus_if.grant, bus_if.ack, bus_if.rdata);
    end
    @(posedge clk);
    #1 bus_if.req = '0;
    @(negedge clk);
    check("cont_idle_busy", bus_if.busy, 0);

    // Table-driven single transactions
    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i].idx, vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
    end

    // Back-to-back: re-request in the IDLE cycle right after the ack
    bus_if.req_rw[0]      = READ;
    bus_if.req_addr[7:0]  = 8'h3C;
    bus_if.req[0]         = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      if (bus_if.ack[0]) seen = 1'b1;
    end
    check("b2b_ack_seen", seen, 1);
    check("b2b_rdata", bus_if.rdata, 8'hA5);
    @(posedge clk);
    #1 bus_if.req[0] = 1'b0;
    @(negedge clk);
    check("b2b_idle_busy",  bus_if.busy, 0);
    check("b2b_idle_start", bus_if.mem_start, 0);
    bus_if.req[0] = 1'b1;
    @(negedge clk);
    check("b2b_start", bus_if.mem_start, 1);
    check("b2b_busy",  bus_if.busy, 1);
    @(negedge clk);
    @(negedge clk);
    check("b2b_ack2", bus_if.ack, 2'b01);
    @(posedge clk);
    #1 bus_if.req[0] = 1'b0;
    @(negedge clk);
    $display("[TB] txn back-to-back req0 READ addr=3c rdata=%02h", bus_if.rdata);

    // Asynchronous reset in the ACCESS cycle of a write by requester 0
    bus_if.req_rw[0]      = WRITE;
    bus_if.req_addr[7:0]  = 8'h20;
    bus_if.req_wdata[7:0] = 8'h77;
    bus_if.req[0]         = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("abort_pre_oe", bus_if.mem_wdata_oe, 1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_oe",    bus_if.mem_wdata_oe, 0);
    check("abort_busy",  bus_if.busy, 0);
    check("abort_grant", bus_if.grant, 0);
    check("abort_addr",  bus_if.mem_addr, 0);
    check("abort_wdata", bus_if.mem_wdata, 0);
    check("abort_rw",    bus_if.mem_rw, 1);
    check("abort_rdata", bus_if.rdata, 0);
    bus_if.req[0] = 1'b0;
    @(negedge clk);
    check("abort_ack", bus_if.ack, 0);
    rst_n = 1'b1;
    // Both request after release; the pointer must be back at 0
    bus_if.req_rw   = 2'b11;
    bus_if.req_addr = {8'h3C, 8'h20};
    bus_if.req      = 2'b11;
    @(negedge clk);
    check("post_rst_grant", bus_if.grant, 2'b01);
    @(negedge clk);
    @(negedge clk);
    check("post_rst_ack",   bus_if.ack, 2'b01);
    check("post_rst_rdata", bus_if.rdata, 8'h00);
    @(posedge clk);
    #1 bus_if.req = '0;
    @(negedge clk);
    $display("[TB] txn post-reset req0 READ addr=20 rdata=%02h", bus_if.rdata);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single 8-bit memory (256 x 8, one transaction per start pulse) between NREQ requesters, e.g. instruction fetch and data load/store.
- Selects one requester and issues its command to the memory interface: start pulse, rW, address.
- Drives write data onto the shared bus only when allowed, captures read data, and returns a one-cycle ack.
- Sits between the CPU sequencer/requesters and the memory.

Parameters:
NREQ, 2, number of requesters (2..4)
ADDR_W, 8, address width
DATA_W, 8, data width

Ports:
CLK  in  1  clock; all state updates on posedge
RST  in  1  asynchronous, active-low reset
req  in  NREQ  request level per requester
req_rw  in  NREQ  per requester: 1=READ, 0=WRITE
req_addr  in  NREQ*ADDR_W  packed addresses, requester i at bits [i*ADDR_W +: ADDR_W]
req_wdata  in  NREQ*DATA_W  packed write data, same packing
ack  out  NREQ  one-hot completion pulse
rdata  out  DATA_W  read data for the acked requester
grant  out  NREQ  one-hot owner, valid ISSUE..RESP
busy  out  1  high whenever state != IDLE
mem_start  out  1  one-cycle start pulse to memory
mem_rw  out  1  READ=1 / WRITE=0, valid with mem_start
mem_addr  out  ADDR_W  transaction address
mem_wdata  out  DATA_W  write data toward the bus
mem_wdata_oe  out  1  bus drive enable for mem_wdata
mem_rdata  in  DATA_W  bus value seen by the arbiter

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE; ack, grant, busy, mem_start, mem_wdata_oe = 0; rdata, mem_addr, mem_wdata = 0; mem_rw=1; round-robin pointer=0. An aborted transaction is dropped silently with no ack.
- FSM states: IDLE, ISSUE, ACCESS, RESP; one cycle each except IDLE.
- IDLE:
  - If any req is high at the posedge, pick a winner and latch its rw, addr and wdata into registers.
  - Set grant to the winner and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: mem_start=1 and mem_rw/mem_addr come from the latched values. mem_wdata_oe=1 if WRITE. Next state is ACCESS.
- ACCESS:
  - WRITE: mem_wdata_oe stays 1 and the memory stores the word during this cycle.
  - READ: mem_wdata_oe=0 and the memory drives the bus; mem_rdata is registered into rdata at the ACCESS->RESP edge.
  - Next state is RESP.
- RESP:
  - ack[grant]=1 for exactly one cycle. rdata is valid for reads and holds until the next read completes; it is unchanged by writes.
  - grant clears on exit to IDLE.
- Latency: req seen at edge k -> mem_start during cycle k+1 -> ack during cycle k+3. Peak throughput is one transaction per 4 cycles.
- Handshake:
  - req is a level and must be held until ack.
  - The requester deasserts req at the edge that ends its ack cycle. A req still high in IDLE is treated as a new request.
  - Inputs may change freely after the IDLE latch edge; the latched values are used.
- Arbitration:
  - Round-robin. The search starts at the pointer; the pointer moves to (winner+1) mod NREQ on each grant.
  - Simultaneous requests are resolved by the pointer; no requester waits more than NREQ-1 grants.
- Bus rule: mem_wdata_oe is never 1 in a read's ACCESS cycle, or in IDLE or RESP, so there is no bus contention.
- mem_wdata is the latched wdata whenever mem_wdata_oe=1, else 0.
- Requests arriving while busy are ignored until IDLE.

Optional Feature:
- MEM_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins. The pointer register is removed. Starvation of higher indices is permitted.
- Undefined: round-robin as above.

Decomposition:
- mem_arb_pkg:
  - state enum (IDLE, ISSUE, ACCESS, RESP)
  - constants READ=1, WRITE=0, ADDR_W=8, DATA_W=8
- One sub-module, mem_rr_pick: combinational pick of a one-hot winner from req and pointer (fixed-priority under the macro), parameterised by NREQ.
- The FSM, the latching and the bus control stay in mem_bus_arbiter.

Test Plan:
- Read: preload mem[0x3C]=0xA5; req[0] READ addr 0x3C -> mem_start in cycle k+1 with mem_rw=1, mem_addr=0x3C; ack[0] in k+3; rdata=0xA5; mem_wdata_oe=0 throughout.
- Write then read: req[1] WRITE 0x10 data 0x5A -> mem_wdata_oe=1 in ISSUE and ACCESS, ack[1]. Then req[0] READ 0x10 -> rdata=0x5A.
- Contention: req[0] and req[1] held high for 4 transactions after reset -> grant order 0,1,0,1; each ack one-hot. Under MEM_ARB_FIXED_PRIO_EN -> order 0,0,0,0.
- Back-to-back: req[0] reasserted the cycle after ack -> next mem_start exactly 2 cycles after the ack cycle; busy drops for exactly one IDLE cycle.
- Reset mid-ACCESS of a WRITE: RST=0 asynchronously -> outputs zero immediately, no ack. After release, a fresh READ works and the pointer restarts at 0.
- Inputs changing after latch: req_addr changed during ISSUE -> mem_addr still the latched value.
